// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames start, W_DATA data bits (LSB first), optional
// parity and stop bits onto tx, steering an external PISO through load/enb.

package uart_pkg;
    localparam int WIDTH = 8;
endpackage

module uart_tx_ctrl #(
    parameter int W_DATA       = uart_pkg::WIDTH,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       piso_out,
    input  logic       piso_parity,
    output logic       piso_load,
    output logic       piso_enb,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_MAX  = (W_DATA > STOP_BITS) ? W_DATA : STOP_BITS;
    localparam int BIT_W    = $clog2(BIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   baud_cnt;
    logic [CNT_W-1:0]   baud_nxt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_nxt;
    logic               done_nxt;
    logic               bit_tick;
    logic               accept;

    // Handshake: start is a level request sampled only while idle; the cycle it
    // is seen high in IDLE is the accept cycle (PISO loads on that edge), and
    // busy stays high from the next cycle until the frame's done cycle.
    assign accept    = (state == S_IDLE) && start && rst;
    assign bit_tick  = (state != S_IDLE) && (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        if ((state == S_IDLE) || bit_tick) begin
            baud_nxt = '0;
        end else begin
            baud_nxt = baud_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        done_nxt  = 1'b0;
        piso_load = 1'b0;
        piso_enb  = 1'b0;
        tx        = 1'b1;
        case (state)
            S_IDLE: begin
                tx = 1'b1;
                if (accept) begin
                    piso_load = 1'b1;
                    piso_enb  = 1'b1;
                    state_nxt = S_START;
                    bit_nxt   = '0;
                end
            end
            S_START: begin
                tx = 1'b0;
                if (bit_tick) begin
                    state_nxt = S_DATA;
                    bit_nxt   = '0;
                end
            end
            S_DATA: begin
                tx = piso_out;
                if (bit_tick) begin
                    // Rotate once per bit; after W_DATA shifts the PISO is back to its load value.
                    piso_enb = 1'b1;
                    if (bit_cnt == BIT_W'(W_DATA - 1)) begin
                        state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                tx = piso_parity ^ (PARITY_ODD != 0);
                if (bit_tick) begin
                    state_nxt = S_STOP;
                    bit_nxt   = '0;
                end
            end
            S_STOP: begin
                tx = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        state_nxt = S_IDLE;
                        bit_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                bit_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: three parameterisations run in lockstep, each with its
// own rotating PISO, checked frame by frame against a bit-list reference model.

module tb_uart_tx_ctrl;

    localparam int N         = 4;
    localparam int FRAME_CYC = 44;
    localparam int NBITS     = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_bus;

    wire [2:0] tx_v, busy_v, done_v, load_v, enb_v, pout_v, ppar_v;
    wire [2:0] st0, st1, st2;
    logic [7:0] piso_q [3];

    int compared = 0;
    int failed   = 0;

    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    // instance 0: even parity, 1 stop; 1: odd parity, 1 stop; 2: no parity, 2 stops
    uart_tx_ctrl #(.W_DATA(8), .CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .start(start), .piso_out(pout_v[0]), .piso_parity(ppar_v[0]),
        .piso_load(load_v[0]), .piso_enb(enb_v[0]), .tx(tx_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .state_dbg(st0));
    uart_tx_ctrl #(.W_DATA(8), .CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .start(start), .piso_out(pout_v[1]), .piso_parity(ppar_v[1]),
        .piso_load(load_v[1]), .piso_enb(enb_v[1]), .tx(tx_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .state_dbg(st1));
    uart_tx_ctrl #(.W_DATA(8), .CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_nopar (
        .clk(clk), .rst(rst), .start(start), .piso_out(pout_v[2]), .piso_parity(ppar_v[2]),
        .piso_load(load_v[2]), .piso_enb(enb_v[2]), .tx(tx_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .state_dbg(st2));

    // rotating PISO models
    initial for (int i = 0; i < 3; i++) piso_q[i] = 8'h00;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (enb_v[i]) piso_q[i] <= load_v[i] ? data_bus : {piso_q[i][0], piso_q[i][7:1]};
        end
    end
    assign pout_v = {piso_q[2][0], piso_q[1][0], piso_q[0][0]};
    assign ppar_v = {^piso_q[2], ^piso_q[1], ^piso_q[0]};

    // ---------------- reference model ----------------
    function automatic logic ref_bit(input int inst, input logic [7:0] d, input int k);
        logic bits [$];
        int   pe;
        int   odd;
        int   sb;
        pe  = (inst == 2) ? 0 : 1;
        odd = (inst == 1) ? 1 : 0;
        sb  = (inst == 2) ? 2 : 1;
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(d[b]);
        if (pe == 1) bits.push_back((^d) ^ (odd == 1));
        for (int s = 0; s < sb; s++) bits.push_back(1'b1);
        return bits[k];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int          idx        [3];
    logic        active     [3];
    logic        prev_busy  [3];
    logic        early_done [3];
    logic [43:0] samp       [3];
    logic [7:0]  cur_data;
    logic        have_exp;

    initial for (int i = 0; i < 3; i++) begin
        active[i] = 1'b0; prev_busy[i] = 1'b0; idx[i] = 0; early_done[i] = 1'b0; samp[i] = '1;
    end

    task automatic check_frame(input int i);
        logic       eb;
        logic [3:0] slot;
        check($sformatf("inst%0d_frame_end{done,busy,early}", i),
              {29'd0, done_v[i], busy_v[i], early_done[i]}, 32'b100);
        if (have_exp) begin
            for (int k = 0; k < NBITS; k++) begin
                eb   = ref_bit(i, cur_data, k);
                slot = samp[i][k*N +: N];
                check($sformatf("inst%0d_data%02h_bit%0d", i, cur_data, k), {28'd0, slot}, {28'd0, {N{eb}}});
            end
            check($sformatf("inst%0d_piso_restored", i), {24'd0, piso_q[i]}, {24'd0, cur_data});
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                active[i]    = 1'b0;
                prev_busy[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i] && !prev_busy[i]) begin
                    if (i == 0) begin
                        if (exp_q.size() == 0) begin
                            have_exp = 1'b0;
                            compared++;
                            failed++;
                            $display("FAIL unexpected_frame: frame started with no request queued at %0t", $time);
                        end else begin
                            have_exp = 1'b1;
                            cur_data = exp_q.pop_front();
                        end
                    end
                    active[i]     = 1'b1;
                    idx[i]        = 0;
                    early_done[i] = 1'b0;
                    samp[i]       = '1;
                end
                if (active[i]) begin
                    if (idx[i] < FRAME_CYC) begin
                        samp[i][idx[i]] = tx_v[i];
                        if (done_v[i]) early_done[i] = 1'b1;
                    end else begin
                        check_frame(i);
                        active[i] = 1'b0;
                    end
                    idx[i]++;
                end
                prev_busy[i] = busy_v[i];
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d);
        int cnt = 0;
        while (busy_v[0] && cnt < 200) begin
            tick(1);
            cnt++;
        end
        check("idle_before_send", {31'd0, busy_v[0]}, 32'd0);
        data_bus = d;
        start    = 1'b1;
        @(posedge clk);
        exp_q.push_back(d);
        #1;
        start    = 1'b0;
        data_bus = 8'($urandom);
    endtask

    task automatic wait_done();
        int cnt = 0;
        while (done_v[0] !== 1'b1 && cnt < 200) begin
            tick(1);
            cnt++;
        end
        check("done_seen", {31'd0, done_v[0]}, 32'd1);
    endtask

    task automatic mid_frame_start();
        tick($urandom_range(2, 40));
        start    = 1'b1;
        data_bus = 8'($urandom);
        tick(1);
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        failed++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b1;
        data_bus = 8'h00;
        tick(3);
        check("reset_tx",   {29'd0, tx_v},   32'b111);
        check("reset_busy", {29'd0, busy_v}, 32'b000);
        check("reset_done", {29'd0, done_v}, 32'b000);
        check("reset_load", {29'd0, load_v}, 32'b000);
        check("reset_enb",  {29'd0, enb_v},  32'b000);
        start = 1'b0;
        rst   = 1'b1;
        tick(3);

        send_frame(8'hA5);
        wait_done();
        send_frame(8'h01);
        wait_done();

        for (int f = 0; f < 8; f++) begin
            send_frame(8'($urandom));
            if ($urandom_range(0, 1) == 1) mid_frame_start();
            wait_done();
            tick($urandom_range(0, 3));
        end

        // back-to-back with start held high
        tick(2);
        data_bus = 8'h3C;
        start    = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'h3C);
        #1;
        data_bus = 8'hC3;
        wait_done();
        @(posedge clk);
        exp_q.push_back(8'hC3);
        #1;
        check("b2b_restart_busy", {29'd0, busy_v}, 32'b111);
        check("b2b_start_bit",    {29'd0, tx_v},   32'b000);
        start    = 1'b0;
        data_bus = 8'h00;
        wait_done();
        tick(2);

        // asynchronous reset during data bit 3
        send_frame(8'h5A);
        tick(17);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_tx",   {29'd0, tx_v},   32'b111);
        check("midreset_busy", {29'd0, busy_v}, 32'b000);
        check("midreset_done", {29'd0, done_v}, 32'b000);
        exp_q.delete();
        tick(2);
        rst = 1'b1;
        tick(2);
        send_frame(8'hE7);
        wait_done();
        tick(5);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit sequencer that drives the `piso_lsb` shift register and turns its serial output into a framed asynchronous line: start bit, W_DATA data bits LSB first, optional parity bit, and stop bit(s). It sits between the system-side send request and the `tx` pin. It owns the bit-rate counter, the frame FSM and the `load`/`enb` controls of the PISO. Data does not pass through this block; the PISO is loaded directly from the data bus when this block asserts `piso_load`.

## Interface
Parameters:
- `W_DATA`: `uart_pkg` width, 8. Data bits per frame. It must equal the PISO width.
- `CLKS_PER_BIT`: 434. Clock cycles per bit period, i.e. 50 MHz / 115200. Legal values are ≥ 2.
- `PARITY_EN`: 1. When 1, a parity bit follows the data bits.
- `PARITY_ODD`: 0. 0 selects even parity; 1 selects odd parity.
- `STOP_BITS`: 1. Legal values are 1 or 2.

Ports:
- `clk`: in, 1. System clock.
- `rst`: in, 1. Asynchronous, active-low reset.
- `start`: in, 1. Transmit request. Sampled only in IDLE.
- `piso_out`: in, 1. Serial bit from the PISO, current LSB.
- `piso_parity`: in, 1. XOR of the PISO register contents (even-parity bit).
- `piso_load`: out, 1. PISO load select.
- `piso_enb`: out, 1. PISO enable (load or shift).
- `tx`: out, 1. Serial line. Idles high.
- `busy`: out, 1. High while a frame is in flight.
- `done`: out, 1. One-cycle pulse after the stop period ends.

## Operation
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **Baud counter:** counts 0..CLKS_PER_BIT-1 and wraps to 0. `bit_tick` is asserted when count == CLKS_PER_BIT-1. The counter is held at 0 in IDLE.
- **Bit counter:** counts 0..W_DATA-1 in DATA, and 0..STOP_BITS-1 in STOP. It is cleared on every state entry.
- **IDLE:**
  - `tx`=1.
  - If `start`=1, drive `piso_load`=1 and `piso_enb`=1 combinationally for that cycle, then go to START.
- **START:**
  - `tx`=0.
  - On `bit_tick`, go to DATA.
- **DATA:**
  - `tx`=`piso_out`.
  - On `bit_tick`, drive `piso_enb`=1 and `piso_load`=0 (one shift).
  - If the bit counter is at W_DATA-1, go to PARITY when PARITY_EN=1, otherwise to STOP.
  - Exactly W_DATA shifts occur, so the PISO register ends with its originally loaded value.
- **PARITY:**
  - `tx`=`piso_parity` XOR PARITY_ODD.
  - Parity is invariant under rotation, so the value is correct at any time.
  - On `bit_tick`, go to STOP.
- **STOP:**
  - `tx`=1.
  - After STOP_BITS bit ticks, go to IDLE and assert `done` on that transition.
- **Outputs and strobes:**
  - `tx` is a combinational mux of state and PISO flops only; it has no other logic inputs.
  - `piso_load`/`piso_enb` are 0 in every case not listed above.
- **`busy` and `done`:**
  - `busy` = (state != IDLE).
  - `done` is registered and is high for exactly the first IDLE cycle after STOP.
- **Start handling:**
  - `start` outside IDLE is ignored; there is no queueing.
  - `start` held high gives back-to-back frames. The new frame is accepted in the same cycle that `done` is high, with no idle gap on `tx`.
- **Reset (asynchronous, any time, including mid-frame):**
  - State goes to IDLE and both counters to 0.
  - `tx`=1, `busy`=0, `done`=0, `piso_load`=0, `piso_enb`=0.
  - After reset the line is high; the partial frame is abandoned.

## Timing
- Let E0 be the clock edge at which `start` is accepted. The PISO loads at E0.
- Start bit: `tx` low from E0 for CLKS_PER_BIT cycles.
- Data bit i (0 = LSB): occupies [E0+(1+i)·N, E0+(2+i)·N), where N=CLKS_PER_BIT.
- Parity bit: occupies [E0+(1+W)·N, E0+(2+W)·N).
- Stop period: follows parity (or data, if parity is off) and lasts STOP_BITS·N cycles.
- Frame length: N·(1+W_DATA+PARITY_EN+STOP_BITS) cycles, from E0 until `done` is high.
- PISO shift pulses: at edges E0+(2+i)·N-1 for i=0..W_DATA-1. The new `piso_out` is visible from the next cycle, which is the first cycle of bit i+1.
- `busy` rises in the cycle after E0 and falls in the cycle where `done` is high.

## Test plan
All scenarios use CLKS_PER_BIT=4 with `piso_lsb` instantiated alongside.
- **Basic frame:** load 0xA5, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1, pulse `start`. Required: `tx` = 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles. `done` pulses 44 cycles after E0. The PISO holds 0xA5 at the end.
- **Parity polarity:** data 0x01. With PARITY_ODD=0 the parity bit is 1; with PARITY_ODD=1 it is 0.
- **Frame options:** PARITY_EN=0 with STOP_BITS=2 gives a 44-cycle frame with no parity slot; the last 8 cycles have `tx`=1.
- **Back-to-back and ignored start:** hold `start` high for two frames (0x3C, then 0xC3). Required: no high gap between the first frame's stop bit and the second frame's start bit. `start` pulses mid-frame do not restart or extend the frame.
- **Reset mid-frame:** assert `rst`=0 during data bit 3. Required: `tx`=1, `busy`=0, `done`=0 immediately, without waiting for a clock edge. After release, the next `start` sends a full, correct frame.
